unstriping: RTL

- Receive-side counterpart of the two-lane striping block.
- Accepts 32-bit words from lane_0 and lane_1 and re-serialises them into one 32-bit stream at clk_2f, in strict order lane_0, lane_1, lane_0, and so on.
- Each lane has a small FIFO to absorb inter-lane skew.
- Sits between the lane receivers and the downstream consumer of data_in-format words.

---
 rtl/unstriping_if.sv | 22 ++
 rtl/unstriping.sv | 117 +++++++++++
 2 files changed

// File: rtl/unstriping_if.sv
// Lane-side and merged-stream signals of the two-lane unstriping block.
interface unstriping_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] lane_0;
    logic              valid_0;
    logic [DATA_W-1:0] lane_1;
    logic              valid_1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [1:0]        overflow_err;

    modport master (
        output lane_0, valid_0, lane_1, valid_1,
        input  data_out, valid_out, overflow_err
    );

    modport slave (
        input  lane_0, valid_0, lane_1, valid_1,
        output data_out, valid_out, overflow_err
    );
endinterface

// File: rtl/unstriping.sv
// Two-lane to one-stream merger: per-lane skew FIFOs drained in strict
// lane 0 / lane 1 alternation, one word per clk_2f at most.
module unstriping #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic        clk_2f,
    input  logic        reset,
    unstriping_if.slave bus
);
    typedef enum logic {SEL0 = 1'b0, SEL1 = 1'b1} sel_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    sel_t              sel;
    sel_t              sel_nxt;
    logic [DATA_W-1:0] mem    [2][DEPTH];
    logic [DATA_W-1:0] din    [2];
    logic [DATA_W-1:0] head   [2];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W:0]    cnt    [2];
    logic [1:0]        vld_in;
    logic [1:0]        full;
    logic [1:0]        empty;
    logic [1:0]        pop;
    logic [1:0]        push;
    logic [1:0]        ovf_set;
    logic [DATA_W-1:0] data_p0;
    logic              vld_p0;
    logic [1:0]        ovf_p0;

    assign din[0] = bus.lane_0;
    assign din[1] = bus.lane_1;
    assign vld_in = {bus.valid_1, bus.valid_0};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]  = (cnt[i] == FULL_CNT);
            empty[i] = (cnt[i] == '0);
            head[i]  = mem[i][rd_ptr[i]];
        end
        pop     = 2'b00;
        sel_nxt = sel;
        // The owed lane is never skipped, even if the other lane has data.
        case (sel)
            SEL0: if (!empty[0]) begin
                pop[0]  = 1'b1;
                sel_nxt = SEL1;
            end
            SEL1: if (!empty[1]) begin
                pop[1]  = 1'b1;
                sel_nxt = SEL0;
            end
            default: sel_nxt = SEL0;
        endcase
        // A full FIFO still accepts a word when its head leaves on the same edge.
        for (int i = 0; i < 2; i++) begin
            push[i]    = vld_in[i] && (!full[i] || pop[i]);
            ovf_set[i] = vld_in[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            sel <= SEL0;
        end else begin
            sel <= sel_nxt;
        end
    end

    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= din[i];
            end
        end
    end

    // Output stage p0: registered merged word, valid and sticky overflow.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            data_p0 <= '0;
            vld_p0  <= 1'b0;
            ovf_p0  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
            vld_p0 <= |pop;
            if (|pop) begin
                data_p0 <= pop[1] ? head[1] : head[0];
            end
            ovf_p0 <= ovf_p0 | ovf_set;
        end
    end

    assign bus.data_out     = data_p0;
    assign bus.valid_out    = vld_p0;
    assign bus.overflow_err = ovf_p0;
endmodule
